flag_branch_resolver: RTL and testbench

- Consumer (read side) of the flags register: takes the stored ZCSO flags and resolves conditional branches for the fetch stage.
- Accepts one branch request over a valid/ready handshake and holds it while an older flag-writing instruction is still in flight.
- Evaluates a 4-bit condition code against ZCSO, then issues a one-cycle PC-load/flush pulse or a not-taken completion.
- Includes a wait timeout and a saturating taken-branch counter.

---
 rtl/flag_branch_resolver.sv | 143 ++++++++++++++
 tb/tb_flag_branch_resolver.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flag_branch_resolver.sv
// Conditional branch resolver on the read side of the ZCSO flags register.
// Ports: clock/reset, ZCSO flags + flag_write (stale marker), kill squash,
//   br_valid/br_ready/br_cond/br_target request handshake,
//   pc_load/pc_target/flush/resolved/timeout_err pulses, taken_count.
module flag_branch_resolver #(
   parameter int ADDR_WIDTH = 16,
   parameter int MAX_WAIT   = 8
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [3:0]            ZCSO,
   input  logic                  flag_write,
   input  logic                  kill,
   input  logic                  br_valid,
   output logic                  br_ready,
   input  logic [3:0]            br_cond,
   input  logic [ADDR_WIDTH-1:0] br_target,
   output logic                  pc_load,
   output logic [ADDR_WIDTH-1:0] pc_target,
   output logic                  flush,
   output logic                  resolved,
   output logic                  timeout_err,
   output logic [15:0]           taken_count
);

   // Wait counter only has to reach MAX_WAIT-1.
   localparam int CW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
   localparam logic [CW-1:0] LAST = CW'(MAX_WAIT - 1);

   typedef enum logic {
      S_IDLE,
      S_WAIT
   } state_t;

   state_t                state_q;
   logic [3:0]            cond_q;
   logic [ADDR_WIDTH-1:0] tgt_q;
   logic [CW-1:0]         cnt_q;
   logic                  pc_load_q;
   logic                  flush_q;
   logic                  resolved_q;
   logic                  timeout_q;
   logic [ADDR_WIDTH-1:0] pc_target_q;
   logic [15:0]           taken_q;

   logic                  hit;
   logic [15:0]           taken_d;

   function automatic logic eval_cond(
      input logic [3:0] c,
      input logic [3:0] f
   );
      logic z, cy, s, o, lt;
      z  = f[0];
      cy = f[1];
      s  = f[2];
      o  = f[3];
      lt = s ^ o;
      case (c)
         4'b0000: eval_cond = 1'b1;
         4'b0001: eval_cond = z;
         4'b0010: eval_cond = ~z;
         4'b0011: eval_cond = cy;
         4'b0100: eval_cond = ~cy;
         4'b0101: eval_cond = s;
         4'b0110: eval_cond = ~s;
         4'b0111: eval_cond = o;
         4'b1000: eval_cond = ~o;
         4'b1001: eval_cond = lt;
         4'b1010: eval_cond = ~lt;
         4'b1011: eval_cond = z | lt;
         4'b1100: eval_cond = ~z & ~lt;
         4'b1101: eval_cond = cy & ~z;
         4'b1110: eval_cond = ~cy | z;
         default: eval_cond = 1'b0;
      endcase
   endfunction

   assign hit = eval_cond(cond_q, ZCSO);

   // Saturating increment of the taken-branch counter.
   assign taken_d = (taken_q == 16'hFFFF) ? taken_q : taken_q + 16'd1;

   // A squash in the same cycle blocks acceptance.
   assign br_ready = (state_q == S_IDLE) & ~kill;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         cond_q      <= '0;
         tgt_q       <= '0;
         cnt_q       <= '0;
         pc_load_q   <= 1'b0;
         flush_q     <= 1'b0;
         resolved_q  <= 1'b0;
         timeout_q   <= 1'b0;
         pc_target_q <= '0;
         taken_q     <= '0;
      end else begin
         pc_load_q  <= 1'b0;
         flush_q    <= 1'b0;
         resolved_q <= 1'b0;
         timeout_q  <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (br_valid && br_ready) begin
                  cond_q  <= br_cond;
                  tgt_q   <= br_target;
                  cnt_q   <= '0;
                  state_q <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (kill) begin
                  state_q <= S_IDLE;
               end else if (!flag_write) begin
                  pc_load_q   <= hit;
                  flush_q     <= hit;
                  pc_target_q <= tgt_q;
                  resolved_q  <= 1'b1;
                  if (hit) taken_q <= taken_d;
                  state_q <= S_IDLE;
               end else if (cnt_q == LAST) begin
                  timeout_q  <= 1'b1;
                  resolved_q <= 1'b1;
                  state_q    <= S_IDLE;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign pc_load     = pc_load_q;
   assign flush       = flush_q;
   assign resolved    = resolved_q;
   assign timeout_err = timeout_q;
   assign pc_target   = pc_target_q;
   assign taken_count = taken_q;

endmodule

// File: tb/tb_flag_branch_resolver.sv
// Self-checking bench for flag_branch_resolver.
// Ports: none (drives and checks the resolver).
module tb_flag_branch_resolver;

   localparam int AW = 16;
   localparam int MW = 8;

   logic          clock = 1'b0;
   logic          reset;
   logic [3:0]    ZCSO;
   logic          flag_write;
   logic          kill;
   logic          br_valid;
   logic          br_ready;
   logic [3:0]    br_cond;
   logic [AW-1:0] br_target;
   logic          pc_load;
   logic [AW-1:0] pc_target;
   logic          flush;
   logic          resolved;
   logic          timeout_err;
   logic [15:0]   taken_count;

   int checks = 0;
   int errors = 0;

   int          m_cnt;
   logic [15:0] m_tgt;

   flag_branch_resolver #(.ADDR_WIDTH(AW), .MAX_WAIT(MW)) dut (
      .clock(clock),
      .reset(reset),
      .ZCSO(ZCSO),
      .flag_write(flag_write),
      .kill(kill),
      .br_valid(br_valid),
      .br_ready(br_ready),
      .br_cond(br_cond),
      .br_target(br_target),
      .pc_load(pc_load),
      .pc_target(pc_target),
      .flush(flush),
      .resolved(resolved),
      .timeout_err(timeout_err),
      .taken_count(taken_count)
   );

   always #5 clock = ~clock;

   initial begin
      #2000000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Reference: flag predicates grouped by pair, odd code = predicate, even = inverse.
   function automatic logic ref_taken(input logic [3:0] c, input logic [3:0] f);
      int   idx;
      logic fl, lt, le, ule;
      lt  = (f[2] != f[3]);
      le  = f[0] || lt;
      ule = !f[1] || f[0];
      if (c == 4'd0) return 1'b1;
      if (c == 4'd15) return 1'b0;
      if (c <= 4'd8) begin
         idx = (int'(c) - 1) / 2;
         fl  = f[idx];
         return c[0] ? fl : !fl;
      end
      case (c)
         4'd9:    return lt;
         4'd10:   return !lt;
         4'd11:   return le;
         4'd12:   return !le;
         4'd13:   return !ule;
         default: return ule;
      endcase
   endfunction

   // Called at a negedge; returns at the negedge after completion,
   // so consecutive calls issue back-to-back requests.
   task automatic run_branch(
      input logic [3:0]  c,
      input logic [15:0] t,
      input logic [3:0]  f,
      input int          w,
      input int          killat,
      input string       tag
   );
      int       r;
      bit       done;
      logic     tk;
      logic [3:0] exp_p;
      logic [3:0] got_p;
      r = (w >= MW) ? MW : w + 1;
      br_valid   = 1'b1;
      br_cond    = c;
      br_target  = t;
      kill       = 1'b0;
      flag_write = (w > 0);
      ZCSO       = (w > 0) ? 4'($urandom) : f;
      #1;
      checks++;
      if (br_ready !== 1'b1) begin
         errors++;
         $display("FAIL %s accept_ready got %b want 1", tag, br_ready);
      end
      @(posedge clock);
      @(negedge clock);
      done = 0;
      for (int e = 1; e <= MW + 1 && !done; e++) begin
         br_valid   = 1'($urandom);
         br_cond    = 4'($urandom);
         br_target  = 16'($urandom);
         flag_write = (e <= w);
         kill       = (e == killat);
         ZCSO       = (e <= w) ? 4'($urandom) : f;
         #1;
         checks++;
         if (br_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s wait_ready e=%0d got %b want 0", tag, e, br_ready);
         end
         @(posedge clock);
         @(negedge clock);
         exp_p = 4'b0000;
         if (e == killat) begin
            done = 1;
         end else if (e == r) begin
            done = 1;
            if (w >= MW) begin
               exp_p = 4'b0011;
            end else begin
               tk    = ref_taken(c, f);
               exp_p = {tk, tk, 2'b10};
               m_tgt = t;
               if (tk && m_cnt < 65535) m_cnt++;
            end
         end
         got_p = {pc_load, flush, resolved, timeout_err};
         checks++;
         if (got_p !== exp_p) begin
            errors++;
            $display("FAIL %s pulses e=%0d got %b want %b (ld,fl,res,to)",
                     tag, e, got_p, exp_p);
         end
         checks++;
         if (pc_target !== m_tgt) begin
            errors++;
            $display("FAIL %s pc_target got %h want %h", tag, pc_target, m_tgt);
         end
         checks++;
         if (taken_count !== 16'(m_cnt)) begin
            errors++;
            $display("FAIL %s taken_count got %h want %h", tag, taken_count, 16'(m_cnt));
         end
      end
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL %s no_completion got 0 want 1", tag);
      end
      br_valid   = 1'b0;
      kill       = 1'b0;
      flag_write = 1'b0;
      #1;
      checks++;
      if (br_ready !== 1'b1) begin
         errors++;
         $display("FAIL %s ready_after got %b want 1", tag, br_ready);
      end
   endtask

   task automatic test_reset();
      logic [3:0] p;
      reset      = 1'b1;
      ZCSO       = 4'b0;
      flag_write = 1'b0;
      kill       = 1'b0;
      br_valid   = 1'b0;
      br_cond    = 4'b0;
      br_target  = '0;
      m_cnt      = 0;
      m_tgt      = '0;
      repeat (2) @(negedge clock);
      reset = 1'b0;
      // Accept, hold in WAIT, then reset asynchronously mid-cycle.
      br_valid   = 1'b1;
      br_cond    = 4'b0000;
      br_target  = 16'hBEEF;
      flag_write = 1'b1;
      @(negedge clock);
      br_valid = 1'b0;
      @(negedge clock);
      #2 reset = 1'b1;
      #1;
      p = {pc_load, flush, resolved, timeout_err};
      checks++;
      if (p !== 4'b0 || pc_target !== '0 || taken_count !== 16'h0) begin
         errors++;
         $display("FAIL reset outputs got p=%b tgt=%h cnt=%h want 0", p, pc_target, taken_count);
      end
      checks++;
      if (br_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset ready got %b want 1", br_ready);
      end
      @(negedge clock);
      reset      = 1'b0;
      flag_write = 1'b0;
      repeat (4) begin
         @(negedge clock);
         p = {pc_load, flush, resolved, timeout_err};
         checks++;
         if (p !== 4'b0 || br_ready !== 1'b1 || taken_count !== 16'h0) begin
            errors++;
            $display("FAIL reset_after got p=%b rdy=%b cnt=%h want 0,1,0",
                     p, br_ready, taken_count);
         end
      end
   endtask

   task automatic test_taken_basic();
      run_branch(4'b0001, 16'h1234, 4'b0001, 0, 0, "taken_z");
   endtask

   task automatic test_signed_lt();
      run_branch(4'b1001, 16'h2000, 4'b1100, 0, 0, "slt_so11");
      run_branch(4'b1001, 16'h2004, 4'b0100, 0, 0, "slt_so10");
   endtask

   task automatic test_flag_wait();
      run_branch(4'b0001, 16'h3000, 4'b0001, 3, 0, "wait3");
      run_branch(4'b0010, 16'h3004, 4'b0001, 1, 0, "wait1_nt");
   endtask

   task automatic test_timeout();
      run_branch(4'b0000, 16'h4000, 4'b0000, MW, 0, "timeout");
      run_branch(4'b0000, 16'h4004, 4'b0000, MW - 1, 0, "last_wait");
      run_branch(4'b0000, 16'h4008, 4'b0000, MW + 1, 0, "timeout_long");
   endtask

   task automatic test_kill();
      logic [3:0] p;
      run_branch(4'b0000, 16'h5000, 4'b0000, 0, 1, "kill_w0");
      run_branch(4'b0000, 16'h5004, 4'b0000, 4, 2, "kill_wait");
      // Squash in IDLE blocks a simultaneous request.
      kill      = 1'b1;
      br_valid  = 1'b1;
      br_cond   = 4'b0000;
      br_target = 16'h5555;
      #1;
      checks++;
      if (br_ready !== 1'b0) begin
         errors++;
         $display("FAIL kill_idle ready got %b want 0", br_ready);
      end
      @(negedge clock);
      kill     = 1'b0;
      br_valid = 1'b0;
      #1;
      checks++;
      if (br_ready !== 1'b1) begin
         errors++;
         $display("FAIL kill_idle not_accepted ready got %b want 1", br_ready);
      end
      @(negedge clock);
      p = {pc_load, flush, resolved, timeout_err};
      checks++;
      if (p !== 4'b0) begin
         errors++;
         $display("FAIL kill_idle pulses got %b want 0000", p);
      end
   endtask

   task automatic test_all_conds();
      for (int c = 0; c < 16; c++)
         for (int f = 0; f < 16; f++)
            run_branch(4'(c), 16'($urandom), 4'(f), 0, 0, "cond_table");
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 150; i++) begin
         int w, r, ka;
         w  = $urandom_range(0, MW + 1);
         r  = (w >= MW) ? MW : w + 1;
         ka = ($urandom_range(0, 3) == 0) ? $urandom_range(1, r) : 0;
         run_branch(4'($urandom), 16'($urandom), 4'($urandom), w, ka, "random");
      end
   endtask

   task automatic test_saturate();
      force dut.taken_q = 16'hFFFE;
      #1;
      release dut.taken_q;
      m_cnt = 65534;
      #1;
      checks++;
      if (taken_count !== 16'hFFFE) begin
         errors++;
         $display("FAIL sat_preload got %h want fffe", taken_count);
      end
      run_branch(4'b0000, 16'h6000, 4'b0000, 0, 0, "sat_to_max");
      run_branch(4'b0000, 16'h6004, 4'b0000, 0, 0, "sat_hold");
      run_branch(4'b0000, 16'h6008, 4'b0000, 2, 0, "sat_hold2");
   endtask

   initial begin
      test_reset();
      test_taken_basic();
      test_signed_lt();
      test_flag_wait();
      test_timeout();
      test_kill();
      test_all_conds();
      test_back_to_back();
      test_saturate();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
